ss_seq: RTL

Save-state sequencer for the mapper save-state port. It is the initiator side of the `ss_act`/`ss_we`/`ss_addr`/`ss_rdat` interface that every mapper implements as a responder. In a save it walks the mapper's state addresses and copies `ss_rdat` into a state buffer. In a restore it replays the buffer into the mapper by driving the data bus with `ss_we` held across complete M2 periods. It sits between the system controller (command side) and the active mapper plus the state buffer RAM.

---
 rtl/ss_seq_pkg.sv | 24 ++
 rtl/m2_edge_det.sv | 24 ++
 rtl/ss_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ss_seq_pkg.sv
// Shared types and constants for the save-state sequencer.
// The VF_WAIT state exists only when SS_VERIFY_EN is defined.
package ss_seq_pkg;

  localparam int SS_ADDR_W = 8;
  localparam int SS_DATA_W = 8;

  localparam logic SS_DIR_SAVE    = 1'b0;
  localparam logic SS_DIR_RESTORE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_CAP,
    WR_FETCH,
    WR_HOLD,
    WR_GAP,
`ifdef SS_VERIFY_EN
    VF_WAIT,
`endif
    FIN
  } ss_state_e;

endpackage

// File: rtl/m2_edge_det.sv
// Two-flop synchroniser for the asynchronous CPU M2 pin, with single-cycle
// rise/fall pulses taken from the synchronised history.
module m2_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic m2,
  output logic rise,
  output logic fall
);

  // hist[1:0] are the synchroniser flops; hist[2] is the previous synced value.
  logic [2:0] hist;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, exactly like the hardware shift chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= '0;
    else        hist <= {hist[1:0], m2};
  end

  assign rise = (hist[2:1] == 2'b01);
  assign fall = (hist[2:1] == 2'b10);

endmodule

// File: rtl/ss_seq.sv
// Save-state sequencer: copies mapper state to a buffer (save) or replays the
// buffer into the mapper (restore). Define SS_VERIFY_EN to add a read-back pass.
module ss_seq
  import ss_seq_pkg::*;
#(
  parameter int SS_LEN  = 128,
  parameter int M2_HOLD = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m2,
  input  logic                 start,
  input  logic                 dir,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 ss_act,
  output logic                 ss_we,
  output logic [SS_ADDR_W-1:0] ss_addr,
  output logic [SS_DATA_W-1:0] ss_wdat,
  input  logic [SS_DATA_W-1:0] ss_rdat,
  output logic [SS_ADDR_W-1:0] buf_addr,
  output logic [SS_DATA_W-1:0] buf_wdat,
  output logic                 buf_we,
  input  logic [SS_DATA_W-1:0] buf_rdat,
  output logic [SS_ADDR_W-1:0] last_addr
);

  localparam int CNT_W = $clog2(M2_HOLD + 1);
  localparam logic [CNT_W-1:0]     HOLD_LAST  = CNT_W'(M2_HOLD - 1);
  localparam logic [CNT_W-1:0]     FETCH_LAT  = CNT_W'(1);
  localparam logic [CNT_W-1:0]     FETCH_DONE = CNT_W'(2);
  localparam logic [SS_ADDR_W-1:0] ADDR_LAST  = SS_ADDR_W'(SS_LEN - 1);

  ss_state_e            state, state_d;
  logic [SS_ADDR_W-1:0] addr_d, last_d;
  logic [SS_DATA_W-1:0] wdat_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic                 rise_seen, rise_seen_d;
  logic                 err_d;
  logic                 m2_rise, m2_fall;
  logic                 active;

  m2_edge_det u_m2_edge_det (
    .clk  (clk),
    .rst_n(rst_n),
    .m2   (m2),
    .rise (m2_rise),
    .fall (m2_fall)
  );

  assign active   = (state != IDLE) && (state != FIN);
  assign busy     = active;
  assign ss_act   = active;
  assign done     = (state == FIN);
  // abort gates the strobes combinationally so the mapper is released at once.
  assign ss_we    = (state == WR_HOLD) && !abort;
  assign buf_we   = (state == RD_CAP) && !abort;
  assign buf_addr = ss_addr;
  assign buf_wdat = ss_rdat;

  // NOTE: every variable gets its default before the case statement, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state;
    addr_d      = ss_addr;
    cnt_d       = cnt;
    rise_seen_d = rise_seen;
    wdat_d      = ss_wdat;
    err_d       = err;
    last_d      = last_addr;

    unique case (state)
      IDLE: if (start) begin
        addr_d      = '0;
        cnt_d       = '0;
        rise_seen_d = 1'b0;
        err_d       = abort;
        if (abort)                      state_d = FIN;
        else if (dir == SS_DIR_RESTORE) state_d = WR_FETCH;
        else                            state_d = RD_WAIT;
      end
      RD_WAIT: if (m2_fall) begin
        if (cnt == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = RD_CAP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RD_CAP: begin
        if (ss_addr == ADDR_LAST) state_d = FIN;
        else begin
          addr_d  = ss_addr + SS_ADDR_W'(1);
          state_d = RD_WAIT;
        end
      end
      WR_FETCH: begin
        // Data is latched one cycle before ss_we rises to give the mapper setup.
        if (cnt == FETCH_LAT) wdat_d = buf_rdat;
        if (cnt == FETCH_DONE) begin
          cnt_d       = '0;
          rise_seen_d = 1'b0;
          state_d     = WR_HOLD;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      WR_HOLD: begin
        if (m2_rise) rise_seen_d = 1'b1;
        if (m2_fall && rise_seen) begin
          if (cnt == HOLD_LAST) begin
            cnt_d   = '0;
            state_d = WR_GAP;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      WR_GAP: if (m2_fall) begin
        if (ss_addr == ADDR_LAST) begin
`ifdef SS_VERIFY_EN
          addr_d  = '0;
          state_d = VF_WAIT;
`else
          state_d = FIN;
`endif
        end else begin
          addr_d  = ss_addr + SS_ADDR_W'(1);
          state_d = WR_FETCH;
        end
      end
`ifdef SS_VERIFY_EN
      VF_WAIT: if (m2_fall) begin
        if (cnt == HOLD_LAST) begin
          cnt_d = '0;
          if (ss_rdat != buf_rdat) err_d = 1'b1;
          if (ss_addr == ADDR_LAST) state_d = FIN;
          else                      addr_d  = ss_addr + SS_ADDR_W'(1);
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort && active) begin
      state_d = FIN;
      addr_d  = ss_addr;
      err_d   = 1'b1;
    end

    if (state_d == FIN && state != FIN) last_d = addr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ss_addr   <= '0;
      cnt       <= '0;
      rise_seen <= 1'b0;
      ss_wdat   <= '0;
      err       <= 1'b0;
      last_addr <= '0;
    end else begin
      state     <= state_d;
      ss_addr   <= addr_d;
      cnt       <= cnt_d;
      rise_seen <= rise_seen_d;
      ss_wdat   <= wdat_d;
      err       <= err_d;
      last_addr <= last_d;
    end
  end

endmodule
